// File: rtl/br_cdc_fifo_pop_flag_mgr_multi_if.sv
// Pop-side flag manager bus: pop request and push count in, occupancy flags
// and the rate-limited published pop count out.
interface br_cdc_fifo_pop_flag_mgr_multi_if #(
  parameter int unsigned Depth       = 2,
  parameter int unsigned MaxPopBeats = 1
);
  localparam int unsigned CountWidth = $clog2(Depth + 1);
  localparam int unsigned BeatsWidth = $clog2(MaxPopBeats + 1);

  logic [BeatsWidth-1:0] pop_beats;
  logic [CountWidth-1:0] push_count_gray;
  logic                  reset_active_push;
  logic [CountWidth-1:0] pop_count_gray;
  logic [CountWidth-1:0] items_next;
  logic [CountWidth-1:0] items;
  logic                  empty_next;
  logic                  empty;
  logic                  almost_empty;
  logic                  underflow_error;
  logic                  reset_active_pop;

  // Read logic / environment side.
  modport master (
    output pop_beats, push_count_gray, reset_active_push,
    input  pop_count_gray, items_next, items, empty_next, empty,
           almost_empty, underflow_error, reset_active_pop
  );

  // Flag manager side.
  modport slave (
    input  pop_beats, push_count_gray, reset_active_push,
    output pop_count_gray, items_next, items, empty_next, empty,
           almost_empty, underflow_error, reset_active_pop
  );
endinterface

// File: rtl/br_cdc_fifo_pop_flag_mgr_multi.sv
// Pop-domain flag manager for a multi-beat-pop CDC FIFO: tracks occupancy from the
// synchronized gray push count and publishes a one-step-per-cycle gray pop count.
module br_cdc_fifo_pop_flag_mgr_multi #(
  parameter int unsigned Depth                = 2,
  parameter int unsigned MaxPopBeats          = 1,
  parameter int unsigned AlmostEmptyThreshold = 1,
  parameter bit          EnableAssertions     = 1'b1
) (
  input logic                               clk,
  input logic                               rst_n,
  br_cdc_fifo_pop_flag_mgr_multi_if.slave   bus
);
  localparam int unsigned CountWidth = $clog2(Depth + 1);
  localparam int unsigned ExtWidth   = CountWidth + 1;
  localparam logic [ExtWidth-1:0]   WrapOffset = ExtWidth'(1) << CountWidth;
  localparam logic [CountWidth-1:0] AeThresh   = CountWidth'(AlmostEmptyThreshold);

  logic [CountWidth-1:0] pop_beats_ext;
  logic [CountWidth-1:0] pop_count;
  logic [CountWidth-1:0] pop_count_next;
  logic [CountWidth-1:0] push_count;
  logic [CountWidth-1:0] push_count_saved;
  logic [CountWidth-1:0] push_visible;
  logic [ExtWidth-1:0]   items_diff;
  logic [CountWidth-1:0] items_next_c;
  logic                  update_en;
  logic [CountWidth-1:0] pub;
  logic [CountWidth-1:0] pop_count_gray_q;
  logic [CountWidth-1:0] items_q;
  logic                  empty_q;
  logic                  almost_empty_q;
  logic                  underflow_q;
  logic                  reset_active_q;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    push_count = '0;
    for (int i = 0; i < int'(CountWidth); i++) begin
      push_count[i] = ^(bus.push_count_gray >> i);
    end
  end

  // While the push side is in reset its count is garbage; use the last good value.
  always_comb begin
    pop_beats_ext  = CountWidth'(bus.pop_beats);
    pop_count_next = pop_count + pop_beats_ext;
    push_visible   = bus.reset_active_push ? push_count_saved : push_count;
    items_diff     = {1'b0, push_visible} + WrapOffset - {1'b0, pop_count_next};
    items_next_c   = CountWidth'(items_diff);
    update_en      = (pop_beats_ext != '0) || !bus.reset_active_push;
  end

  // Exact pop count and the saved push count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count        <= '0;
      push_count_saved <= '0;
    end else begin
      pop_count <= pop_count_next;
      if (!bus.reset_active_push) push_count_saved <= push_count;
    end
  end

  // Occupancy flags; held while the push side is in reset and nothing pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      items_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else if (update_en) begin
      items_q        <= items_next_c;
      empty_q        <= (items_next_c == '0);
      almost_empty_q <= (items_next_c <= AeThresh);
    end
  end

  // Publisher trails the true pop count one step per cycle so the gray bus
  // crossing to the push side only ever flips one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pub              <= '0;
      pop_count_gray_q <= '0;
    end else begin
      if (pub != pop_count_next) pub <= pub + CountWidth'(1);
      pop_count_gray_q <= pub ^ (pub >> 1);
    end
  end

  // Sticky underflow and pop-side reset indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q    <= 1'b0;
      reset_active_q <= 1'b1;
    end else begin
      if (pop_beats_ext > items_q) underflow_q <= 1'b1;
      reset_active_q <= 1'b0;
    end
  end

  assign bus.pop_count_gray   = pop_count_gray_q;
  assign bus.items_next       = items_next_c;
  assign bus.items            = items_q;
  assign bus.empty_next       = (items_next_c == '0);
  assign bus.empty            = empty_q;
  assign bus.almost_empty     = almost_empty_q;
  assign bus.underflow_error  = underflow_q;
  assign bus.reset_active_pop = reset_active_q;

  if (EnableAssertions) begin : g_asserts
    localparam logic [CountWidth-1:0] DepthC    = CountWidth'(Depth);
    localparam logic [CountWidth-1:0] MaxBeatsC = CountWidth'(MaxPopBeats);

    a_items_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
      items_next_c <= DepthC);
    a_pub_backlog: assert property (@(posedge clk) disable iff (!rst_n)
      (pop_count_next - pub) <= DepthC);
    a_beats_le_max: assert property (@(posedge clk) disable iff (!rst_n)
      pop_beats_ext <= MaxBeatsC);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      pop_beats_ext <= items_q);
  end
endmodule

// File: tb/tb_br_cdc_fifo_pop_flag_mgr_multi.sv
// Bench for the pop flag manager: vector table, publisher/reset/underflow
// sequences and a randomized wrap run against an integer occupancy model.
module tb_br_cdc_fifo_pop_flag_mgr_multi;
  localparam int Depth = 5;
  localparam int MaxPopBeats = 3;
  localparam int AeThr = 1;
  localparam int NumVec = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  br_cdc_fifo_pop_flag_mgr_multi_if #(.Depth(Depth), .MaxPopBeats(MaxPopBeats)) bus ();

  br_cdc_fifo_pop_flag_mgr_multi #(
    .Depth(Depth), .MaxPopBeats(MaxPopBeats), .AlmostEmptyThreshold(AeThr),
    .EnableAssertions(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int push;   // cumulative push count (binary, tb gray-encodes it)
    int beats;
    bit rap;
    int items;
    bit empty;
    bit ae;
  } vec_t;

  typedef struct {
    int items;
    bit empty;
    bit ae;
    bit uf;
    int gray;
    bit chk_gray;
  } exp_t;

  vec_t vecs[NumVec];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic int gray(input int v);
    int b;
    b = v & 7;
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_items"}, int'(bus.items), 0);
    check({tag, "_empty"}, int'(bus.empty), 1);
    check({tag, "_ae"}, int'(bus.almost_empty), 1);
    check({tag, "_uf"}, int'(bus.underflow_error), 0);
    check({tag, "_gray"}, int'(bus.pop_count_gray), 0);
    check({tag, "_rap"}, int'(bus.reset_active_pop), 1);
  endtask

  // Advance one clock and compare registered outputs with the oldest expectation.
  task automatic edge_and_compare(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_items"}, int'(bus.items), e.items);
      check({tag, "_empty"}, int'(bus.empty), int'(e.empty));
      check({tag, "_ae"}, int'(bus.almost_empty), int'(e.ae));
      check({tag, "_uf"}, int'(bus.underflow_error), int'(e.uf));
      if (e.chk_gray) check({tag, "_gray"}, int'(bus.pop_count_gray), e.gray);
    end
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_rap_held"}, int'(bus.reset_active_pop), 1);
    @(posedge clk);
    #1;
    check({tag, "_rap_drop"}, int'(bus.reset_active_pop), 0);
    check({tag, "_gray_after"}, int'(bus.pop_count_gray), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int push_t, pop_t, pub_m, items_m, beats, inc, maxb, exp_next;
    int gray_seq[4];

    vecs[0]  = '{0, 0, 1'b0, 0, 1'b1, 1'b1};
    vecs[1]  = '{5, 0, 1'b0, 5, 1'b0, 1'b0};
    vecs[2]  = '{5, 3, 1'b0, 2, 1'b0, 1'b0};
    vecs[3]  = '{5, 1, 1'b0, 1, 1'b0, 1'b1};
    vecs[4]  = '{6, 0, 1'b0, 2, 1'b0, 1'b0};
    vecs[5]  = '{6, 2, 1'b0, 0, 1'b1, 1'b1};
    vecs[6]  = '{9, 0, 1'b0, 3, 1'b0, 1'b0};
    vecs[7]  = '{9, 1, 1'b0, 2, 1'b0, 1'b0};
    vecs[8]  = '{9, 1, 1'b0, 1, 1'b0, 1'b1};
    vecs[9]  = '{9, 1, 1'b0, 0, 1'b1, 1'b1};
    vecs[10] = '{12, 0, 1'b0, 3, 1'b0, 1'b0};
    vecs[11] = '{7, 0, 1'b1, 3, 1'b0, 1'b0};   // garbage push count, frozen
    vecs[12] = '{2, 1, 1'b1, 2, 1'b0, 1'b0};   // pop against saved count
    vecs[13] = '{6, 0, 1'b1, 2, 1'b0, 1'b0};
    vecs[14] = '{12, 0, 1'b0, 2, 1'b0, 1'b0};
    gray_seq = '{1, 3, 2, 2};

    bus.pop_beats = '0;
    bus.push_count_gray = '0;
    bus.reset_active_push = 1'b0;

    // Power-on reset
    #3 rst_n = 1'b0;
    #1 check_reset("por");
    release_reset("por");

    // Fill to 5, then a 3-beat pop drained by the publisher one step per cycle
    @(negedge clk);
    bus.push_count_gray = 3'(gray(5));
    #1 check("fill_items_next", int'(bus.items_next), 5);
    @(posedge clk);
    #1;
    check("fill_items", int'(bus.items), 5);
    check("fill_empty", int'(bus.empty), 0);
    @(negedge clk);
    bus.pop_beats = 2'd3;
    @(posedge clk);
    #1;
    check("pop3_items", int'(bus.items), 2);
    check("pop3_gray_t1", int'(bus.pop_count_gray), 0);
    @(negedge clk);
    bus.pop_beats = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 check($sformatf("pop3_gray_t%0d", k + 2), int'(bus.pop_count_gray), gray_seq[k]);
    end

    // Build a publisher backlog of 2, then reset asynchronously without a clock
    @(negedge clk);
    bus.push_count_gray = 3'(gray(8));
    bus.pop_beats = 2'd3;
    @(posedge clk);
    #1;
    check("burst_gray_pre", int'(bus.pop_count_gray), gray(3));
    rst_n = 1'b0;
    #1 check_reset("async");
    bus.pop_beats = '0;
    bus.push_count_gray = '0;
    release_reset("async");
    @(posedge clk);
    #1 check("async_gray_idle", int'(bus.pop_count_gray), 0);

    // Vector table
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      bus.push_count_gray = 3'(gray(vecs[i].push));
      bus.pop_beats = 2'(vecs[i].beats);
      bus.reset_active_push = vecs[i].rap;
      #1;
      check($sformatf("vec%0d_items_next", i), int'(bus.items_next), vecs[i].items);
      check($sformatf("vec%0d_empty_next", i), int'(bus.empty_next), int'(vecs[i].items == 0));
      e = '{vecs[i].items, vecs[i].empty, vecs[i].ae, 1'b0, 0, 1'b0};
      sb.push_back(e);
      edge_and_compare($sformatf("vec%0d", i));
    end

    // Underflow: pop 1 to reach items=1, then pop 2
    @(negedge clk);
    bus.pop_beats = 2'd1;
    sb.push_back('{1, 1'b0, 1'b1, 1'b0, 0, 1'b0});
    edge_and_compare("uf_pre");
    @(negedge clk);
    bus.pop_beats = 2'd2;
    @(posedge clk);
    #1 check("uf_set", int'(bus.underflow_error), 1);
    @(negedge clk);
    bus.pop_beats = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check($sformatf("uf_sticky%0d", k), int'(bus.underflow_error), 1);
    end
    rst_n = 1'b0;
    bus.push_count_gray = '0;
    #1 check("uf_cleared", int'(bus.underflow_error), 0);
    release_reset("uf");

    // Randomized push/pop through counter wrap against an integer model
    push_t = 0; pop_t = 0; pub_m = 0; items_m = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      maxb = (items_m < MaxPopBeats) ? items_m : MaxPopBeats;
      if (maxb > Depth - (pop_t - pub_m)) maxb = Depth - (pop_t - pub_m);
      beats = int'($urandom_range(maxb, 0));
      inc = int'($urandom_range(Depth - items_m + beats, 0));
      push_t += inc;
      bus.push_count_gray = 3'(gray(push_t));
      bus.pop_beats = 2'(beats);
      exp_next = push_t - (pop_t + beats);
      #1 check($sformatf("rnd%0d_items_next", c), int'(bus.items_next), exp_next);
      e.gray = gray(pub_m);
      if (pub_m != pop_t + beats) pub_m++;
      pop_t += beats;
      items_m = exp_next;
      e.items = items_m;
      e.empty = (items_m == 0);
      e.ae = (items_m <= AeThr);
      e.uf = 1'b0;
      e.chk_gray = 1'b1;
      sb.push_back(e);
      edge_and_compare($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
